// File: rtl/ray_scheduler_pkg.sv
// Shared definitions for the ray scheduler slice.
//   sched_state_t : frame scheduler states
//   COLOR_BITS    : width of one framebuffer color sample
//   FSEL_BITS     : width of the fractal select field
package ray_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } sched_state_t;

    localparam int unsigned COLOR_BITS = 4;
    localparam int unsigned FSEL_BITS  = 3;

endpackage

// File: rtl/ray_scheduler_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
//   req      : request vector
//   ptr      : highest-priority index this cycle
//   grant    : one-hot grant (zero when nothing requests)
//   valid    : any request granted
//   ptr_next : index one past the granted requester (modulo N)
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic                 valid,
    output logic [$clog2(N)-1:0] ptr_next
);

    localparam int unsigned PW = $clog2(N);

    logic [PW-1:0] idx;

    // Scan from ptr upward, wrapping; first requester wins.
    always_comb begin
        grant    = '0;
        valid    = 1'b0;
        ptr_next = ptr;
        idx      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PW'((32'(ptr) + k) % N);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
                ptr_next   = (32'(idx) + 32'd1 == N) ? '0 : PW'(32'(idx) + 32'd1);
            end
        end
    end

endmodule

// File: rtl/ray_scheduler.sv
// Frame scheduler for a pool of ray_unit cores.
// Walks the frame in raster order, dispatching each pixel to an idle core
// (round-robin), and funnels finished cores onto one framebuffer write port.
//   clk_in / rst_n_in         : clock, async active-low reset
//   start_in, fractal_sel_in  : frame trigger and fractal select (latched at start)
//   core_*_in                 : per-core ready / result bundle
//   core_valid_out, hcount_out, vcount_out, fractal_sel_out : dispatch to cores
//   wr_*_out                  : framebuffer write port
//   busy_out, frame_done_out  : status
module ray_scheduler
    import ray_scheduler_pkg::*;
#(
    parameter int unsigned DISPLAY_WIDTH  = 400,
    parameter int unsigned DISPLAY_HEIGHT = 300,
    parameter int unsigned H_BITS         = 9,
    parameter int unsigned V_BITS         = 9,
    parameter int unsigned NUM_CORES      = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            start_in,
    input  logic [FSEL_BITS-1:0]            fractal_sel_in,
    input  logic [NUM_CORES-1:0]            core_ready_in,
    input  logic [NUM_CORES*H_BITS-1:0]     core_hcount_in,
    input  logic [NUM_CORES*V_BITS-1:0]     core_vcount_in,
    input  logic [NUM_CORES*COLOR_BITS-1:0] core_color_in,
    output logic [NUM_CORES-1:0]            core_valid_out,
    output logic [H_BITS-1:0]               hcount_out,
    output logic [V_BITS-1:0]               vcount_out,
    output logic [FSEL_BITS-1:0]            fractal_sel_out,
    output logic                            wr_en_out,
    output logic [H_BITS-1:0]               wr_hcount_out,
    output logic [V_BITS-1:0]               wr_vcount_out,
    output logic [COLOR_BITS-1:0]           wr_color_out,
    output logic                            busy_out,
    output logic                            frame_done_out
);

    localparam int unsigned PW = $clog2(NUM_CORES);

    sched_state_t          state;
    logic [H_BITS-1:0]     h;
    logic [V_BITS-1:0]     v;
    logic [NUM_CORES-1:0]  pending;
    logic [NUM_CORES-1:0]  cooldown;
    logic [PW-1:0]         dp;
    logic [PW-1:0]         wp;

    logic [NUM_CORES-1:0]  disp_req;
    logic [NUM_CORES-1:0]  disp_grant;
    logic                  disp_valid;
    logic [PW-1:0]         dp_next;
    logic [NUM_CORES-1:0]  wr_req;
    logic [NUM_CORES-1:0]  wr_grant;
    logic                  wr_valid;
    logic [PW-1:0]         wp_next;
    logic [PW-1:0]         wr_idx;
    logic                  h_last;
    logic                  v_last;

    // Request vectors; cooldown hides a core's stale ready in the cycle valid is shown.
    always_comb begin
        disp_req = '0;
        wr_req   = '0;
        if (state == ST_DISPATCH) begin
            disp_req = core_ready_in & ~pending;
        end
        if (state == ST_DISPATCH || state == ST_DRAIN) begin
            wr_req = pending & ~cooldown & core_ready_in;
        end
        wr_idx = (wp_next == '0) ? PW'(NUM_CORES - 1) : wp_next - PW'(1);
        h_last = (h == H_BITS'(DISPLAY_WIDTH - 1));
        v_last = (v == V_BITS'(DISPLAY_HEIGHT - 1));
    end

    rr_arbiter #(.N(NUM_CORES)) u_disp_arb (
        .req      (disp_req),
        .ptr      (dp),
        .grant    (disp_grant),
        .valid    (disp_valid),
        .ptr_next (dp_next)
    );

    rr_arbiter #(.N(NUM_CORES)) u_wr_arb (
        .req      (wr_req),
        .ptr      (wp),
        .grant    (wr_grant),
        .valid    (wr_valid),
        .ptr_next (wp_next)
    );

    // Scheduler FSM, pixel walk, per-core bookkeeping and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= ST_IDLE;
            h               <= '0;
            v               <= '0;
            pending         <= '0;
            cooldown        <= '0;
            dp              <= '0;
            wp              <= '0;
            core_valid_out  <= '0;
            hcount_out      <= '0;
            vcount_out      <= '0;
            fractal_sel_out <= '0;
            wr_en_out       <= 1'b0;
            wr_hcount_out   <= '0;
            wr_vcount_out   <= '0;
            wr_color_out    <= '0;
            busy_out        <= 1'b0;
            frame_done_out  <= 1'b0;
        end else begin
            core_valid_out <= '0;
            wr_en_out      <= 1'b0;
            frame_done_out <= 1'b0;
            // Grants are disjoint: dispatch needs !pending, write-back needs pending.
            pending        <= (pending | disp_grant) & ~wr_grant;
            cooldown       <= disp_grant;

            if (wr_valid) begin
                wr_en_out     <= 1'b1;
                wr_hcount_out <= core_hcount_in[32'(wr_idx)*H_BITS +: H_BITS];
                wr_vcount_out <= core_vcount_in[32'(wr_idx)*V_BITS +: V_BITS];
                wr_color_out  <= core_color_in[32'(wr_idx)*COLOR_BITS +: COLOR_BITS];
                wp            <= wp_next;
            end

            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        state           <= ST_DISPATCH;
                        fractal_sel_out <= fractal_sel_in;
                        h               <= '0;
                        v               <= '0;
                        busy_out        <= 1'b1;
                    end
                end
                ST_DISPATCH: begin
                    if (disp_valid) begin
                        core_valid_out <= disp_grant;
                        hcount_out     <= h;
                        vcount_out     <= v;
                        dp             <= dp_next;
                        if (h_last) begin
                            h <= '0;
                            if (v_last) begin
                                v     <= '0;
                                state <= ST_DRAIN;
                            end else begin
                                v <= v + V_BITS'(1);
                            end
                        end else begin
                            h <= h + H_BITS'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pending == '0 && !wr_valid) begin
                        state          <= ST_DONE;
                        frame_done_out <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    busy_out <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ray_scheduler.sv
// Directed bench for ray_scheduler on a 4x2 frame with four behavioural cores.
module tb_ray_scheduler;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned HB = 9;
    localparam int unsigned VB = 9;
    localparam int unsigned NC = 4;
    localparam int unsigned CB = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [2:0]        fsel;
    logic [NC-1:0]     core_ready;
    logic [NC*HB-1:0]  core_hcount;
    logic [NC*VB-1:0]  core_vcount;
    logic [NC*CB-1:0]  core_color;
    logic [NC-1:0]     core_valid;
    logic [HB-1:0]     hcount;
    logic [VB-1:0]     vcount;
    logic [2:0]        fsel_out;
    logic              wr_en;
    logic [HB-1:0]     wr_hcount;
    logic [VB-1:0]     wr_vcount;
    logic [CB-1:0]     wr_color;
    logic              busy;
    logic              frame_done;

    always #5 clk = ~clk;

    ray_scheduler #(
        .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .H_BITS(HB), .V_BITS(VB), .NUM_CORES(NC)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .fractal_sel_in(fsel),
        .core_ready_in(core_ready), .core_hcount_in(core_hcount),
        .core_vcount_in(core_vcount), .core_color_in(core_color),
        .core_valid_out(core_valid), .hcount_out(hcount), .vcount_out(vcount),
        .fractal_sel_out(fsel_out), .wr_en_out(wr_en), .wr_hcount_out(wr_hcount),
        .wr_vcount_out(wr_vcount), .wr_color_out(wr_color), .busy_out(busy),
        .frame_done_out(frame_done)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CB-1:0] color_of(input int hh, input int vv);
        return CB'(hh * 5 + vv * 3 + 1);
    endfunction

    // Behavioural ray_unit: drops ready when it samples valid, raises it lat cycles later.
    int            lat [NC];
    logic [HB-1:0] m_h [NC];
    logic [VB-1:0] m_v [NC];
    logic [CB-1:0] m_c [NC];
    int            m_cnt [NC];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NC; i++) begin
                core_ready[i] <= 1'b1;
                m_cnt[i]      <= 0;
                m_h[i]        <= '0;
                m_v[i]        <= '0;
                m_c[i]        <= '0;
            end
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (core_valid[i]) begin
                    core_ready[i] <= 1'b0;
                    m_cnt[i]      <= lat[i];
                    m_h[i]        <= hcount;
                    m_v[i]        <= vcount;
                    m_c[i]        <= color_of(int'(hcount), int'(vcount));
                end else if (!core_ready[i]) begin
                    if (m_cnt[i] <= 1) core_ready[i] <= 1'b1;
                    else               m_cnt[i] <= m_cnt[i] - 1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NC; i++) begin
            core_hcount[i*HB +: HB] = m_h[i];
            core_vcount[i*VB +: VB] = m_v[i];
            core_color[i*CB +: CB]  = m_c[i];
        end
    end

    // Event logs, filled on the falling edge.
    int cyc = 0;
    int d_h [256], d_v [256], d_core [256], d_cyc [256];
    int w_h [256], w_v [256], w_cyc [256];
    int done_cyc [16];
    int nd = 0, nw = 0, ndone = 0, nbad = 0;
    int owner [H][W];
    bit written [H][W];
    bit outstanding [NC];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int c;
        int hh;
        int vv;
        c = 0;
        if (core_valid != '0) begin
            if ($countones(core_valid) != 1) nbad++;
            for (int i = 0; i < NC; i++) if (core_valid[i]) c = i;
            hh = int'(hcount);
            vv = int'(vcount);
            if (hh == 0 && vv == 0) begin
                for (int y = 0; y < H; y++)
                    for (int x = 0; x < W; x++) begin
                        owner[y][x]   = -1;
                        written[y][x] = 1'b0;
                    end
                for (int i = 0; i < NC; i++) outstanding[i] = 1'b0;
            end
            if (outstanding[c]) nbad++;
            outstanding[c] = 1'b1;
            if (hh < W && vv < H) owner[vv][hh] = c;
            else nbad++;
            d_h[nd] = hh; d_v[nd] = vv; d_core[nd] = c; d_cyc[nd] = cyc;
            nd++;
        end
        if (wr_en) begin
            hh = int'(wr_hcount);
            vv = int'(wr_vcount);
            if (hh >= W || vv >= H) nbad++;
            else begin
                if (owner[vv][hh] < 0 || written[vv][hh]) nbad++;
                else begin
                    written[vv][hh] = 1'b1;
                    outstanding[owner[vv][hh]] = 1'b0;
                end
                if (wr_color != color_of(hh, vv)) nbad++;
            end
            w_h[nw] = hh; w_v[nw] = vv; w_cyc[nw] = cyc;
            nw++;
        end
        if (frame_done) begin
            done_cyc[ndone] = cyc;
            ndone++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (ndone < target && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check(tag, 64'(ndone >= target), 64'd1);
    endtask

    task automatic wait_disp(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (nd < target && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check(tag, 64'(nd >= target), 64'd1);
    endtask

    task automatic pulse_start(input logic [2:0] sel);
        fsel  = sel;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({core_valid, hcount, vcount, fsel_out, wr_en, wr_hcount,
                    wr_vcount, wr_color, busy, frame_done});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, w0, b0, n0, cnt2, p2;
        rst_n = 1'b0;
        start = 1'b0;
        fsel  = 3'd0;
        for (int i = 0; i < NC; i++) lat[i] = 5;
        #2;
        check("reset_outputs", all_outs(), 64'd0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Frame B: uniform 5-cycle cores.
        d0 = nd; w0 = nw; b0 = nbad; n0 = ndone;
        pulse_start(3'd5);
        wait_done(n0 + 1, 400, "b_done_seen");
        tick(3);
        check("b_dispatches", 64'(nd - d0), 64'd8);
        check("b_writes", 64'(nw - w0), 64'd8);
        check("b_done_count", 64'(ndone - n0), 64'd1);
        for (int i = 0; i < 8; i++)
            check($sformatf("b_raster_%0d", i), 64'(d_v[d0+i] * 16 + d_h[d0+i]),
                  64'((i / 4) * 16 + (i % 4)));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b_core_%0d", i), 64'(d_core[d0+i]), 64'(i));
            check($sformatf("b_cyc_%0d", i), 64'(d_cyc[d0+i] - d_cyc[d0]), 64'(i));
        end
        check("b_integrity", 64'(nbad - b0), 64'd0);
        check("b_done_after_write", 64'(done_cyc[n0] > w_cyc[nw-1]), 64'd1);
        check("b_fsel", 64'(fsel_out), 64'd5);
        check("b_idle_busy", 64'(busy), 64'd0);

        // Frame C: reset mid-dispatch, then staggered latencies that finish together.
        pulse_start(3'd3);
        tick(2);
        check("c_busy_before_reset", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("c_async_reset_outputs", all_outs(), 64'd0);
        tick(2);
        rst_n = 1'b1;
        lat[0] = 8; lat[1] = 7; lat[2] = 6; lat[3] = 5;
        tick(1);
        d0 = nd; w0 = nw; b0 = nbad; n0 = ndone;
        pulse_start(3'd1);
        wait_done(n0 + 1, 400, "c_done_seen");
        tick(3);
        check("c_first_pixel", 64'(d_v[d0] * 16 + d_h[d0]), 64'd0);
        check("c_dispatches", 64'(nd - d0), 64'd8);
        check("c_writes", 64'(nw - w0), 64'd8);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("c_wr_order_%0d", i), 64'(w_v[w0+i] * 16 + w_h[w0+i]), 64'(i));
            check($sformatf("c_wr_cyc_%0d", i), 64'(w_cyc[w0+i] - w_cyc[w0]), 64'(i));
        end
        check("c_integrity", 64'(nbad - b0), 64'd0);
        check("c_fsel", 64'(fsel_out), 64'd1);

        // Frame D: core 2 stays busy long after the others finish.
        lat[0] = 3; lat[1] = 3; lat[2] = 60; lat[3] = 3;
        d0 = nd; w0 = nw; b0 = nbad; n0 = ndone;
        pulse_start(3'd4);
        wait_disp(d0 + 8, 200, "d_all_dispatched");
        tick(5);
        check("d_drain_busy", 64'(busy), 64'd1);
        check("d_drain_no_done", 64'(ndone - n0), 64'd0);
        wait_done(n0 + 1, 300, "d_done_seen");
        tick(2);
        cnt2 = 0; p2 = -1;
        for (int j = d0; j < nd; j++)
            if (d_core[j] == 2) begin
                cnt2++;
                p2 = d_v[j] * 16 + d_h[j];
            end
        check("d_core2_dispatches", 64'(cnt2), 64'd1);
        check("d_writes", 64'(nw - w0), 64'd8);
        check("d_last_write_core2", 64'(w_v[nw-1] * 16 + w_h[nw-1]), 64'(p2));
        check("d_done_after_write", 64'(done_cyc[n0] > w_cyc[nw-1]), 64'd1);
        check("d_integrity", 64'(nbad - b0), 64'd0);

        // Frame E: start held high; fractal select changes mid-frame.
        for (int i = 0; i < NC; i++) lat[i] = 3;
        d0 = nd; w0 = nw; b0 = nbad; n0 = ndone;
        fsel  = 3'd2;
        start = 1'b1;
        tick(4);
        fsel = 3'd6;
        check("e_fsel_midframe", 64'(fsel_out), 64'd2);
        wait_done(n0 + 1, 400, "e_done1_seen");
        check("e_fsel_at_done", 64'(fsel_out), 64'd2);
        check("e_one_frame", 64'(nd - d0), 64'd8);
        wait_disp(d0 + 9, 50, "e_restart_seen");
        check("e_restart_pixel", 64'(d_v[d0+8] * 16 + d_h[d0+8]), 64'd0);
        check("e_restart_after_done", 64'(d_cyc[d0+8] > done_cyc[n0]), 64'd1);
        check("e_fsel_relatched", 64'(fsel_out), 64'd6);
        start = 1'b0;
        wait_done(n0 + 2, 400, "e_done2_seen");
        tick(3);
        check("e_dispatches", 64'(nd - d0), 64'd16);
        check("e_writes", 64'(nw - w0), 64'd16);
        check("e_integrity", 64'(nbad - b0), 64'd0);
        check("e_idle_busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
